// File: rtl/occ_fetch_unit.sv
// Occ fetch unit: takes one (k, l) request, reads the symbol's Occ count at k and/or l
// from a ROM with a variable-latency valid, and returns both counts with a timeout flag.
module occ_fetch_unit #(
  parameter int NSYM   = 4,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 17,
  parameter int TMO    = 15,
  localparam int SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_mode,
  input  logic [SYM_W-1:0]        req_sym,
  input  logic [ADDR_W-1:0]       req_k,
  input  logic [ADDR_W-1:0]       req_l,
  input  logic [TAG_W-1:0]        req_tag,
  output logic                    ce_rom,
  output logic [ADDR_W-1:0]       addr_rom,
  input  logic [NSYM*CNT_W-1:0]   rom_data,
  input  logic                    rom_valid,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [CNT_W-1:0]        rsp_occ_k,
  output logic [CNT_W-1:0]        rsp_occ_l,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    rsp_err
);

  localparam int WAIT_W = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [WAIT_W-1:0] TMO_C = WAIT_W'(TMO);

  typedef enum logic [1:0] {IDLE, RD_K, RD_L, RSP} state_t;

  state_t              state_q, state_d;
  logic [SYM_W-1:0]    sym_q;
  logic [ADDR_W-1:0]   k_q, l_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [CNT_W-1:0]    lane;
  logic                timeout;
  logic                ce_d;
  logic [ADDR_W-1:0]   addr_d;

  // Out-of-range symbols (only possible when NSYM is not a power of two) read as 0.
  always_comb begin
    lane = '0;
    for (int s = 0; s < NSYM; s++) begin
      if (sym_q == SYM_W'(s)) lane = rom_data[s*CNT_W +: CNT_W];
    end
  end

  // A valid in the same cycle the counter hits TMO still wins over the timeout.
  assign timeout   = (wait_q == TMO_C) && !rom_valid;
  assign req_ready = rst_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    addr_d  = '0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        unique case (req_mode)
          2'b10:   state_d = RD_K;
          2'b01:   state_d = RD_L;
          default: state_d = RSP;
        endcase
      end
      RD_K: if (rom_valid || timeout) state_d = RD_L;
      RD_L: if (rom_valid || timeout) state_d = RSP;
      RSP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // ROM controls are registered, so they are computed from the state being entered.
    unique case (state_d)
      RD_K: begin
        ce_d   = 1'b1;
        addr_d = (state_q == IDLE) ? req_k : k_q;
      end
      RD_L: begin
        ce_d   = 1'b1;
        addr_d = (state_q == IDLE) ? req_l : l_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ce_rom    <= 1'b0;
      addr_rom  <= '0;
      wait_q    <= '0;
      sym_q     <= '0;
      k_q       <= '0;
      l_q       <= '0;
      rsp_tag   <= '0;
      rsp_occ_k <= '0;
      rsp_occ_l <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ce_rom   <= ce_d;
      addr_rom <= addr_d;

      if (state_d != state_q)
        wait_q <= '0;
      else if ((state_q == RD_K || state_q == RD_L) && !rom_valid)
        wait_q <= wait_q + 1'b1;

      unique case (state_q)
        IDLE: if (req_valid) begin
          sym_q     <= req_sym;
          k_q       <= req_k;
          l_q       <= req_l;
          rsp_tag   <= req_tag;
          rsp_occ_k <= '0;
          rsp_occ_l <= '0;
          rsp_err   <= 1'b0;
        end
        RD_K: begin
          if (rom_valid) rsp_occ_k <= lane;
          else if (timeout) begin
            rsp_occ_k <= '0;
            rsp_err   <= 1'b1;
          end
        end
        RD_L: begin
          if (rom_valid) rsp_occ_l <= lane;
          else if (timeout) begin
            rsp_occ_l <= '0;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_occ_fetch_unit.sv
// Self-checking bench for occ_fetch_unit: ROM responder with per-access latency,
// directed scenarios followed by randomized requests against a transaction-level model.
module tb_occ_fetch_unit;
  localparam int NSYM = 4, CNT_W = 8, ADDR_W = 8, TAG_W = 17, TMO = 15;
  localparam int SYM_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req_valid, req_ready;
  logic [1:0]            req_mode;
  logic [SYM_W-1:0]      req_sym;
  logic [ADDR_W-1:0]     req_k, req_l;
  logic [TAG_W-1:0]      req_tag;
  logic                  ce_rom;
  logic [ADDR_W-1:0]     addr_rom;
  logic [NSYM*CNT_W-1:0] rom_data;
  logic                  rom_valid;
  logic                  rsp_valid, rsp_ready;
  logic [CNT_W-1:0]      rsp_occ_k, rsp_occ_l;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  rsp_err;

  int vectors = 0;
  int miscompares = 0;

  // ROM contents and responder knobs: latency of first/second access (0 = never valid).
  logic [31:0] rom_mem [256];
  int lat_a = 1, lat_b = 1;
  bit junk = 0;

  occ_fetch_unit #(.NSYM(NSYM), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_sym(req_sym),
    .req_k(req_k), .req_l(req_l), .req_tag(req_tag),
    .ce_rom(ce_rom), .addr_rom(addr_rom), .rom_data(rom_data), .rom_valid(rom_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_occ_k(rsp_occ_k), .rsp_occ_l(rsp_occ_l),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ROM responder: counts enabled cycles per access; an access ends on valid or at the timeout.
  initial begin
    int acc_cyc, acc_idx, lat;
    acc_cyc = 0; acc_idx = 0;
    rom_valid = 1'b0; rom_data = '0;
    forever begin
      @(negedge clk);
      rom_valid = 1'b0;
      rom_data  = $urandom;
      if (!rst_n || !ce_rom) begin
        acc_cyc = 0; acc_idx = 0;
        if (junk && ce_rom === 1'b0) rom_valid = 1'b1;
      end else begin
        acc_cyc++;
        lat = (acc_idx == 0) ? lat_a : lat_b;
        if (acc_cyc == lat) begin
          rom_valid = 1'b1;
          rom_data  = rom_mem[addr_rom];
        end
        if (acc_cyc == lat || acc_cyc == TMO + 1) begin
          acc_cyc = 0; acc_idx++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input int lat);
    return (lat >= 1 && lat <= TMO + 1) ? lat : TMO + 1;
  endfunction

  function automatic logic [7:0] lane_of(input logic [31:0] w, input int sym);
    return 8'((w >> (sym * CNT_W)) & 32'hFF);
  endfunction

  task automatic send(input logic [1:0] m, input int s, input logic [7:0] k, input logic [7:0] l,
                      input logic [16:0] t);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_mode = m; req_sym = SYM_W'(s);
    req_k = k; req_l = l; req_tag = t;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // One full transaction: accept, fetch, hold response for `hold` cycles, handshake.
  task automatic do_txn(input logic [1:0] m, input int s, input logic [7:0] k, input logic [7:0] l,
                        input logic [16:0] t, input int la, input int lb, input int hold,
                        input bit busy);
    int wa, wb, exp_lat, exp_ce, n, ce_n, addr_bad;
    logic [7:0] ek, el, a_first, a_second;
    logic ee;
    wa = wait_of(la); wb = wait_of(lb);
    ek = 0; el = 0; ee = 0; exp_ce = 0; exp_lat = 1;
    a_first = 0; a_second = 0;
    if (m == 2'b10) begin
      exp_lat = 1 + wa + wb; exp_ce = wa + wb; a_first = k; a_second = l;
      ek = (la >= 1 && la <= TMO + 1) ? lane_of(rom_mem[k], s) : 8'h0;
      el = (lb >= 1 && lb <= TMO + 1) ? lane_of(rom_mem[l], s) : 8'h0;
      ee = (wa != la) || (wb != lb);
    end else if (m == 2'b01) begin
      exp_lat = 1 + wa; exp_ce = wa; a_first = l; a_second = l;
      el = (la >= 1 && la <= TMO + 1) ? lane_of(rom_mem[l], s) : 8'h0;
      ee = (wa != la);
    end
    lat_a = la; lat_b = lb;
    send(m, s, k, l, t);
    ce_n = 0; addr_bad = 0; n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      n = c;
      if (rsp_valid === 1'b1) break;
      if (ce_rom === 1'b1) begin
        ce_n++;
        if (addr_rom !== ((ce_n <= wa) ? a_first : a_second)) addr_bad++;
      end else if (addr_rom !== 8'h0) addr_bad++;
      if (c == 100) n = 101;
    end
    check("latency", n, exp_lat);
    check("ce_cycles", ce_n, exp_ce);
    check("addr_errors", addr_bad, 0);
    check("occ_k", rsp_occ_k, ek);
    check("occ_l", rsp_occ_l, el);
    check("tag", rsp_tag, t);
    check("err", rsp_err, ee);
    check("ready_in_rsp", req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      if (busy) begin
        req_valid = 1'b1; req_mode = 2'b10; req_k = 8'($urandom); req_tag = 17'($urandom);
      end
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_ready", req_ready, 0);
      check("hold_bundle", {rsp_occ_k, rsp_occ_l, rsp_tag, rsp_err}, {ek, el, t, ee});
      check("hold_ce", ce_rom, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_ready", req_ready, 1);
  endtask

  initial begin
    int seen;
    foreach (rom_mem[i]) rom_mem[i] = $urandom;
    rst_n = 1'b0; req_valid = 1'b0; req_mode = '0; req_sym = '0;
    req_k = '0; req_l = '0; req_tag = '0; rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_outputs", {ce_rom, addr_rom, rsp_valid, rsp_occ_k, rsp_occ_l, rsp_tag, rsp_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);

    // Mode 10, sym 2, single-cycle ROM latency.
    rom_mem[8'h05] = 32'hAA33BBCC;
    rom_mem[8'h09] = 32'h11772233;
    do_txn(2'b10, 2, 8'h05, 8'h09, 17'h00123, 1, 1, 0, 0);
    // Mode 01 single access.
    rom_mem[8'h10] = 32'h44332211;
    do_txn(2'b01, 0, 8'h77, 8'h10, 17'h00456, 1, 1, 0, 0);
    // Bypass and reserved mode.
    do_txn(2'b00, 1, 8'h05, 8'h09, 17'h1ABCD, 1, 1, 0, 0);
    do_txn(2'b11, 3, 8'h05, 8'h09, 17'h0BEEF, 1, 1, 0, 0);
    // Double timeout, then the next request must come back clean.
    do_txn(2'b10, 1, 8'h21, 8'h22, 17'h00777, 0, 0, 0, 0);
    do_txn(2'b10, 2, 8'h05, 8'h09, 17'h00778, 2, 3, 0, 0);
    // Timeout on k only still performs the l read; valid exactly at the limit is data.
    do_txn(2'b10, 3, 8'h30, 8'h31, 17'h00779, 0, 2, 0, 0);
    do_txn(2'b10, 0, 8'h40, 8'h41, 17'h0077A, 16, 1, 0, 0);
    // Back-pressure with a competing request and stray rom_valid outside reads.
    junk = 1;
    do_txn(2'b10, 1, 8'h50, 8'h51, 17'h0ACE1, 3, 1, 5, 1);
    junk = 0;

    // Reset during RD_L discards the request.
    lat_a = 1; lat_b = 0;
    send(2'b10, 2, 8'h60, 8'h61, 17'h0DEAD);
    repeat (3) @(negedge clk);
    check("mid_ce", ce_rom, 1);
    check("mid_addr", addr_rom, 8'h61);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", {ce_rom, addr_rom, rsp_valid, rsp_occ_k, rsp_occ_l, rsp_tag, rsp_err}, 0);
    check("mid_rst_ready", req_ready, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    check("no_rsp_after_rst", seen, 0);
    do_txn(2'b10, 2, 8'h05, 8'h09, 17'h00999, 1, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      int la, lb, pick;
      pick = $urandom_range(0, 9);
      la = (pick == 0) ? 0 : (pick == 1) ? $urandom_range(15, 17) : $urandom_range(1, 5);
      pick = $urandom_range(0, 9);
      lb = (pick == 0) ? 0 : (pick == 1) ? $urandom_range(15, 17) : $urandom_range(1, 5);
      junk = 1'($urandom);
      do_txn(2'($urandom), $urandom_range(0, 3), 8'($urandom), 8'($urandom), 17'($urandom),
             la, lb, $urandom_range(0, 3), 1'($urandom));
    end
    junk = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
